// File: rtl/uc_seq.sv
// Control unit for the microc datapath: single-cycle instruction decode gated by a
// run-control FSM (boot, free-run, single-step, halt) plus an executed-instruction counter.
module uc_seq #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             z,
   input  logic             run_mode,
   input  logic             step_req,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we,
   output logic             wez,
   output logic [2:0]       ALUOp,
   output logic             pc_en,
   output logic             step_ack,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_RUN,
      ST_WAIT,
      ST_STEP,
      ST_HALT
   } state_t;

   localparam logic [5:0] OP_HALT = 6'b111111;

   state_t     state;
   state_t     state_next;
   logic       exec;
   logic       is_halt;
   logic       is_illegal;
   logic       dec_s_inc;
   logic       dec_s_inm;
   logic       dec_we;
   logic       dec_wez;
   logic [2:0] dec_alu_op;
   logic       dec_pc_en;

   assign exec    = (state == ST_RUN) || (state == ST_STEP);
   assign is_halt = (opcode == OP_HALT);

   // Raw instruction decode; only reaches the outputs during EXEC cycles.
   always_comb begin
      dec_s_inc  = 1'b1;
      dec_s_inm  = 1'b0;
      dec_we     = 1'b0;
      dec_wez    = 1'b0;
      dec_alu_op = 3'b000;
      dec_pc_en  = 1'b1;
      is_illegal = 1'b0;
      casez (opcode)
         6'b000000: ;
         6'b001???: begin
            dec_we     = 1'b1;
            dec_wez    = 1'b1;
            dec_alu_op = opcode[2:0];
         end
         6'b01????: begin
            dec_we     = 1'b1;
            dec_s_inm  = 1'b1;
            dec_alu_op = opcode[2:0];
            dec_wez    = |opcode[2:0];
         end
         6'b100000: dec_s_inc = 1'b0;
         6'b100001: dec_s_inc = ~z;
         6'b100010: dec_s_inc = z;
         6'b111111: dec_pc_en = 1'b0;
         default:   is_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_BOOT: state_next = run_mode ? ST_RUN : ST_WAIT;
         ST_RUN: begin
            if (is_halt)
               state_next = ST_HALT;
            else if (!run_mode)
               state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (step_req)
               state_next = ST_STEP;
            else if (run_mode)
               state_next = ST_RUN;
         end
         ST_STEP: state_next = is_halt ? ST_HALT : ST_WAIT;
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_BOOT;
      endcase
   end

   always_comb begin
      s_inc = 1'b1;
      s_inm = 1'b0;
      we    = 1'b0;
      wez   = 1'b0;
      ALUOp = 3'b000;
      pc_en = 1'b0;
      if (exec) begin
         s_inc = dec_s_inc;
         s_inm = dec_s_inm;
         we    = dec_we;
         wez   = dec_wez;
         ALUOp = dec_alu_op;
         pc_en = dec_pc_en;
      end
   end

   assign halted = (state == ST_HALT);

   // HALT is not counted as an executed instruction and never acknowledges a step.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_BOOT;
         instr_cnt <= '0;
         illegal   <= 1'b0;
         step_ack  <= 1'b0;
      end else begin
         state    <= state_next;
         step_ack <= (state == ST_STEP) && !is_halt;
         if (exec && !is_halt)
            instr_cnt <= instr_cnt + CNT_W'(1);
         if (exec && is_illegal)
            illegal <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uc_seq.sv
// Directed bench for uc_seq: a behavioural model pushes expected outputs into a
// scoreboard each cycle; a 4-bit counter instance checks wrap-around in parallel.
module tb_uc_seq;

   localparam int S_BOOT = 0;
   localparam int S_RUN  = 1;
   localparam int S_WAIT = 2;
   localparam int S_STEP = 3;
   localparam int S_HALT = 4;

   typedef struct packed {
      logic [10:0] ctl;
      logic [15:0] cnt;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode;
   logic        z;
   logic        run_mode;
   logic        step_req;

   logic        s_inc, s_inm, we, wez, pc_en, step_ack, halted, illegal;
   logic [2:0]  ALUOp;
   logic [15:0] instr_cnt;

   logic        s_inc4, s_inm4, we4, wez4, pc_en4, step_ack4, halted4, illegal4;
   logic [2:0]  ALUOp4;
   logic [3:0]  instr_cnt4;

   exp_t        sb[$];
   int          passCount;
   int          totalCount;

   int          mState;
   logic [15:0] mCnt;
   logic        mIll;
   logic        mAck;

   uc_seq #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .z(z), .run_mode(run_mode),
      .step_req(step_req), .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez),
      .ALUOp(ALUOp), .pc_en(pc_en), .step_ack(step_ack), .halted(halted),
      .illegal(illegal), .instr_cnt(instr_cnt)
   );

   uc_seq #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .opcode(opcode), .z(z), .run_mode(run_mode),
      .step_req(step_req), .s_inc(s_inc4), .s_inm(s_inm4), .we(we4), .wez(wez4),
      .ALUOp(ALUOp4), .pc_en(pc_en4), .step_ack(step_ack4), .halted(halted4),
      .illegal(illegal4), .instr_cnt(instr_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {s_inc,s_inm,we,wez,ALUOp,pc_en,step_ack,halted,illegal} for the current cycle.
   function automatic logic [10:0] expectedCtl(input int st, input logic [5:0] op, input logic zz,
                                               input logic ack, input logic ill);
      logic       eInc, eInm, eWe, eWez, ePc;
      logic [2:0] eAlu;
      eInc = 1'b1; eInm = 1'b0; eWe = 1'b0; eWez = 1'b0; eAlu = 3'b000; ePc = 1'b0;
      if (st == S_RUN || st == S_STEP) begin
         ePc = 1'b1;
         if (op[5:3] == 3'b001) begin
            eWe = 1'b1; eWez = 1'b1; eAlu = op[2:0];
         end else if (op[5:4] == 2'b01) begin
            eWe = 1'b1; eInm = 1'b1; eAlu = op[2:0]; eWez = (op[2:0] != 3'b000);
         end else if (op == 6'b100000) begin
            eInc = 1'b0;
         end else if (op == 6'b100001) begin
            eInc = !zz;
         end else if (op == 6'b100010) begin
            eInc = zz;
         end else if (op == 6'b111111) begin
            ePc = 1'b0;
         end
      end
      return {eInc, eInm, eWe, eWez, eAlu, ePc, ack, (st == S_HALT), ill};
   endfunction

   function automatic logic opIsLegal(input logic [5:0] op);
      return (op == 6'b000000) || (op[5:3] == 3'b001) || (op[5:4] == 2'b01) ||
             (op == 6'b100000) || (op == 6'b100001) || (op == 6'b100010) || (op == 6'b111111);
   endfunction

   task automatic checkOutput(input string tag);
      exp_t e;
      logic [10:0] ctl;
      logic [10:0] ctl4;
      totalCount++;
      assert (sb.size() > 0) passCount++;
      else $error("[TB] FAIL %s scoreboard: observed empty queue, expected one entry", tag);
      if (sb.size() > 0) begin
         e    = sb.pop_front();
         ctl  = {s_inc, s_inm, we, wez, ALUOp, pc_en, step_ack, halted, illegal};
         ctl4 = {s_inc4, s_inm4, we4, wez4, ALUOp4, pc_en4, step_ack4, halted4, illegal4};
         totalCount++;
         assert (ctl === e.ctl) passCount++;
         else $error("[TB] FAIL %s ctl: observed %b expected %b", tag, ctl, e.ctl);
         totalCount++;
         assert (instr_cnt === e.cnt) passCount++;
         else $error("[TB] FAIL %s instr_cnt: observed %0d expected %0d", tag, instr_cnt, e.cnt);
         totalCount++;
         assert (ctl4 === e.ctl) passCount++;
         else $error("[TB] FAIL %s ctl4: observed %b expected %b", tag, ctl4, e.ctl);
         totalCount++;
         assert (instr_cnt4 === e.cnt[3:0]) passCount++;
         else $error("[TB] FAIL %s instr_cnt4: observed %0d expected %0d", tag, instr_cnt4, e.cnt[3:0]);
      end
   endtask

   // One clock cycle: drive inputs, push the expected outputs, check, then advance the model.
   task automatic applyStimulus(input string tag, input logic rst, input logic rm, input logic sr,
                                input logic [5:0] op, input logic zz);
      logic isExec;
      @(negedge clk);
      reset = rst; run_mode = rm; step_req = sr; opcode = op; z = zz;
      sb.push_back('{ctl: expectedCtl(mState, op, zz, mAck, mIll), cnt: mCnt});
      #2;
      checkOutput(tag);
      @(posedge clk);
      isExec = (mState == S_RUN) || (mState == S_STEP);
      if (rst) begin
         mState = S_BOOT; mCnt = '0; mIll = 1'b0; mAck = 1'b0;
      end else begin
         mAck = (mState == S_STEP) && (op != 6'b111111);
         if (isExec && op != 6'b111111) mCnt = mCnt + 16'd1;
         if (isExec && !opIsLegal(op)) mIll = 1'b1;
         case (mState)
            S_BOOT: mState = rm ? S_RUN : S_WAIT;
            S_RUN:  if (op == 6'b111111) mState = S_HALT; else if (!rm) mState = S_WAIT;
            S_WAIT: if (sr) mState = S_STEP; else if (rm) mState = S_RUN;
            S_STEP: mState = (op == 6'b111111) ? S_HALT : S_WAIT;
            default: mState = S_HALT;
         endcase
      end
   endtask

   initial begin
      passCount = 0; totalCount = 0;
      reset = 1'b1; run_mode = 1'b1; step_req = 1'b0; opcode = 6'b001011; z = 1'b0;
      repeat (2) @(posedge clk);
      mState = S_BOOT; mCnt = '0; mIll = 1'b0; mAck = 1'b0;

      // Boot then first ALU instruction
      applyStimulus("boot",     0, 1, 0, 6'b001011, 0);
      applyStimulus("alu011",   0, 1, 0, 6'b001011, 0);
      // Branches and immediates in free run
      applyStimulus("jnz_z0",   0, 1, 0, 6'b100010, 0);
      applyStimulus("jnz_z1",   0, 1, 0, 6'b100010, 1);
      applyStimulus("jz_z0",    0, 1, 0, 6'b100001, 0);
      applyStimulus("jz_z1",    0, 1, 0, 6'b100001, 1);
      applyStimulus("li",       0, 1, 0, 6'b010000, 0);
      applyStimulus("imm101",   0, 1, 0, 6'b011101, 1);
      applyStimulus("jump",     0, 1, 0, 6'b100000, 1);
      applyStimulus("nop",      0, 1, 0, 6'b000000, 0);
      // Leave free run: this cycle still executes
      applyStimulus("run2wait", 0, 0, 0, 6'b001001, 0);
      for (int p = 0; p < 3; p++) begin
         applyStimulus("step_req", 0, 0, 1, 6'b001110, 0);
         for (int k = 0; k < 4; k++)
            applyStimulus("step_gap", 0, 0, 0, 6'b001110, 0);
      end
      // Held request re-steps once per WAIT->STEP pass
      for (int k = 0; k < 5; k++)
         applyStimulus("step_held", 0, 0, 1, 6'b010101, 0);
      applyStimulus("held_end", 0, 0, 0, 6'b000000, 0);
      applyStimulus("held_end", 0, 0, 0, 6'b000000, 0);
      // Back to free run, then an undefined opcode
      applyStimulus("wait2run", 0, 1, 0, 6'b000000, 0);
      applyStimulus("illegal",  0, 1, 0, 6'b110101, 0);
      applyStimulus("ill_stk",  0, 1, 0, 6'b000000, 0);
      applyStimulus("ill_stk2", 0, 1, 0, 6'b100011, 1);
      applyStimulus("ill_stk3", 0, 1, 0, 6'b001000, 0);
      // HALT is absorbing
      applyStimulus("halt",     0, 1, 0, 6'b111111, 0);
      applyStimulus("halted",   0, 0, 1, 6'b001011, 0);
      applyStimulus("halted2",  0, 1, 0, 6'b001011, 0);
      applyStimulus("halted3",  0, 0, 1, 6'b000000, 1);
      // Reset from HALT, then 17 executed instructions wrap the 4-bit counter to 1
      applyStimulus("rst_halt", 1, 1, 0, 6'b000000, 0);
      applyStimulus("boot2",    0, 1, 0, 6'b001010, 0);
      for (int k = 0; k < 17; k++)
         applyStimulus("wrap", 0, 1, 0, 6'b001010, 0);
      applyStimulus("wrap_end", 0, 0, 0, 6'b000000, 0);
      // Reset asserted during a STEP cycle suppresses step_ack
      applyStimulus("pre_step", 0, 0, 1, 6'b000000, 0);
      applyStimulus("rst_step", 1, 0, 0, 6'b001111, 0);
      applyStimulus("post_rst", 0, 0, 0, 6'b001111, 0);
      applyStimulus("post_rs2", 0, 0, 0, 6'b001111, 0);
      // Stepped HALT gives no step_ack
      applyStimulus("stp_halt", 0, 0, 1, 6'b111111, 0);
      applyStimulus("stp_halt", 0, 0, 0, 6'b111111, 0);
      applyStimulus("stp_hlt2", 0, 0, 0, 6'b000000, 0);
      applyStimulus("stp_hlt3", 0, 0, 0, 6'b000000, 0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
